// File: rtl/regfile_mp_if.sv
// regfile_mp_if: port bundle of the multi-port register file.
// master = core side (drives addresses/writes), slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic              RdyA;
  logic              RdyB;
  logic              We0;
  logic [ADDR_W-1:0] Wa0;
  logic [DATA_W-1:0] Wd0;
  logic              We1;
  logic [ADDR_W-1:0] Wa1;
  logic [DATA_W-1:0] Wd1;
  logic              MarkEn;
  logic [ADDR_W-1:0] MarkAddr;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;
  logic              AnyPending;

  modport master (
    output RA, RB,
    output We0, Wa0, Wd0,
    output We1, Wa1, Wd1,
    output MarkEn, MarkAddr,
    output DbgAddr,
    input  BusA, BusB,
    input  RdyA, RdyB,
    input  DbgData, AnyPending
  );

  modport slave (
    input  RA, RB,
    input  We0, Wa0, Wd0,
    input  We1, Wa1, Wd1,
    input  MarkEn, MarkAddr,
    input  DbgAddr,
    output BusA, BusB,
    output RdyA, RdyB,
    output DbgData, AnyPending
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2W/2R register file, write-first forwarding, load scoreboard.
// Ports: Clk, Rst (sync, active-high), bus (regfile_mp_if.slave).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         Clk,
  input logic         Rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nx;

  logic [DATA_W-1:0] bus_a_q;
  logic [DATA_W-1:0] bus_b_q;
  logic              rdy_a_q;
  logic              rdy_b_q;

  logic              acc0;
  logic              acc1;
  logic              mark_ok;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              ok_a;
  logic              ok_b;
  logic              zero_a;
  logic              zero_b;

  assign acc0 = bus.We0 &&
    !(ZERO_REG && bus.Wa0 == '0);
  assign acc1 = bus.We1 &&
    !(ZERO_REG && bus.Wa1 == '0);
  assign mark_ok = bus.MarkEn &&
    !(ZERO_REG && bus.MarkAddr == '0);

  // A new mark beats a clear: another load is outstanding.
  always_comb begin
    pend_nx = pend;
    if (acc1)
      pend_nx[bus.Wa1] = 1'b0;
    if (mark_ok)
      pend_nx[bus.MarkAddr] = 1'b1;
  end

  assign zero_a = ZERO_REG && bus.RA == '0;
  assign zero_b = ZERO_REG && bus.RB == '0;

  // W1 (load) has priority over W0 (ALU).
  always_comb begin
    rd_a = mem[bus.RA];
    if (zero_a)
      rd_a = '0;
    else if (acc1 && bus.Wa1 == bus.RA)
      rd_a = bus.Wd1;
    else if (acc0 && bus.Wa0 == bus.RA)
      rd_a = bus.Wd0;
  end

  always_comb begin
    rd_b = mem[bus.RB];
    if (zero_b)
      rd_b = '0;
    else if (acc1 && bus.Wa1 == bus.RB)
      rd_b = bus.Wd1;
    else if (acc0 && bus.Wa0 == bus.RB)
      rd_b = bus.Wd0;
  end

  assign ok_a = zero_a || !pend_nx[bus.RA];
  assign ok_b = zero_b || !pend_nx[bus.RB];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      pend    <= '0;
      bus_a_q <= '0;
      bus_b_q <= '0;
      rdy_a_q <= 1'b1;
      rdy_b_q <= 1'b1;
    end else begin
      if (acc0)
        mem[bus.Wa0] <= bus.Wd0;
      // Later assignment wins on a W0/W1 collision.
      if (acc1)
        mem[bus.Wa1] <= bus.Wd1;
      pend    <= pend_nx;
      bus_a_q <= rd_a;
      bus_b_q <= rd_b;
      rdy_a_q <= ok_a;
      rdy_b_q <= ok_b;
    end
  end

  assign bus.BusA = bus_a_q;
  assign bus.BusB = bus_b_q;
  assign bus.RdyA = rdy_a_q;
  assign bus.RdyB = rdy_b_q;

  assign bus.DbgData =
    (ZERO_REG && bus.DbgAddr == '0) ?
    '0 : mem[bus.DbgAddr];

  assign bus.AnyPending = |pend;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector bench for regfile_mp.
// One vector = one clock; outputs checked 1ns after posedge.
module tb_regfile_mp;
  logic clk;
  logic rst;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        mk;
    logic [4:0]  ma;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  dbg;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_ra;
    logic        e_rb;
    logic        e_any;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t vecs [$];
  int checks = 0;
  int errors = 0;

  task automatic check(
    input string name, input int idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
        name, idx, act, exp);
    end
  endtask

  task automatic add(
    input logic r,
    input logic w0, input logic [4:0] a0,
    input logic [31:0] d0,
    input logic w1, input logic [4:0] a1,
    input logic [31:0] d1,
    input logic m, input logic [4:0] mad,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic [4:0] dg,
    input logic [31:0] ea, input logic [31:0] eb,
    input logic era, input logic erb,
    input logic eany, input logic [31:0] edbg
  );
    vec_t v;
    v.rst = r;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.mk = m; v.ma = mad;
    v.ra = ra; v.rb = rb; v.dbg = dg;
    v.e_a = ea; v.e_b = eb;
    v.e_ra = era; v.e_rb = erb;
    v.e_any = eany; v.e_dbg = edbg;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst          = v.rst;
    bus.We0      = v.we0;
    bus.Wa0      = v.wa0;
    bus.Wd0      = v.wd0;
    bus.We1      = v.we1;
    bus.Wa1      = v.wa1;
    bus.Wd1      = v.wd1;
    bus.MarkEn   = v.mk;
    bus.MarkAddr = v.ma;
    bus.RA       = v.ra;
    bus.RB       = v.rb;
    bus.DbgAddr  = v.dbg;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int idx);
    drive(v);
    check("BusA", idx, bus.BusA, v.e_a);
    check("BusB", idx, bus.BusB, v.e_b);
    check("RdyA", idx, 32'(bus.RdyA), 32'(v.e_ra));
    check("RdyB", idx, 32'(bus.RdyB), 32'(v.e_rb));
    check("AnyPending", idx,
      32'(bus.AnyPending), 32'(v.e_any));
    check("DbgData", idx, bus.DbgData, v.e_dbg);
  endtask

  initial begin
    rst = 1'b1;
    bus.We0 = 0; bus.Wa0 = 0; bus.Wd0 = 0;
    bus.We1 = 0; bus.Wa1 = 0; bus.Wd1 = 0;
    bus.MarkEn = 0; bus.MarkAddr = 0;
    bus.RA = 0; bus.RB = 0; bus.DbgAddr = 0;

    // reset, then idle read of 3/0
    add(1, 0,0,0, 0,0,0, 0,0, 3,0,0,
        0, 0, 1,1, 0, 0);
    add(0, 0,0,0, 0,0,0, 0,0, 3,0,0,
        0, 0, 1,1, 0, 0);
    // same-cycle W0 forward
    add(0, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0,5,
        32'hDEADBEEF, 0, 1,1, 0, 32'hDEADBEEF);
    // W0/W1 collision on 7
    add(0, 1,7,32'h11, 1,7,32'h22, 0,0, 7,5,7,
        32'h22, 32'hDEADBEEF, 1,1, 0, 32'h22);
    // scoreboard on 9
    add(0, 0,0,0, 0,0,0, 1,9, 9,7,9,
        0, 32'h22, 0,1, 1, 0);
    add(0, 0,0,0, 0,0,0, 0,0, 9,7,9,
        0, 32'h22, 0,1, 1, 0);
    add(0, 0,0,0, 0,0,0, 0,0, 9,7,9,
        0, 32'h22, 0,1, 1, 0);
    add(0, 0,0,0, 1,9,32'h55, 0,0, 9,9,9,
        32'h55, 32'h55, 1,1, 0, 32'h55);
    // mark/clear race on 4
    add(0, 0,0,0, 0,0,0, 1,4, 4,9,4,
        0, 32'h55, 0,1, 1, 0);
    add(0, 0,0,0, 1,4,32'h44, 1,4, 4,4,4,
        32'h44, 32'h44, 0,0, 1, 32'h44);
    // zero register: mark and write ignored
    add(0, 0,0,0, 0,0,0, 1,0, 0,4,0,
        0, 32'h44, 1,0, 1, 0);
    add(0, 1,0,32'hFF, 0,0,0, 0,0, 0,0,0,
        0, 0, 1,1, 1, 0);
    // W0 does not clear pending
    add(0, 1,4,32'h99, 0,0,0, 0,0, 4,9,4,
        32'h99, 32'h55, 0,1, 1, 32'h99);
    add(0, 0,0,0, 1,4,32'hAB, 0,0, 4,4,4,
        32'hAB, 32'hAB, 1,1, 0, 32'hAB);
    // independent W0/W1 addresses
    add(0, 1,10,32'h1010, 1,11,32'h1111, 0,0,
        10,11,10,
        32'h1010, 32'h1111, 1,1, 0, 32'h1010);

    foreach (vecs[i]) run(vecs[i], i);

    // reset mid-load: 2 and 6 pending with data
    begin
      vec_t v;
      v = vecs[1];
      v.mk = 1; v.ma = 2;
      v.we0 = 1; v.wa0 = 6; v.wd0 = 32'h6666;
      drive(v);
      v.ma = 6;
      v.wa0 = 2; v.wd0 = 32'h2222;
      v.ra = 2; v.rb = 6; v.dbg = 6;
      drive(v);
      check("pre_any", 100,
        32'(bus.AnyPending), 32'd1);
      check("pre_dbg6", 100, bus.DbgData,
        32'h6666);
      check("pre_rdyb", 100, 32'(bus.RdyB), 32'd0);

      v = vecs[1];
      v.rst = 1;
      v.we1 = 1; v.wa1 = 2; v.wd1 = 32'h77;
      v.ra = 2; v.rb = 6; v.dbg = 2;
      v.e_a = 0; v.e_b = 0;
      v.e_ra = 1; v.e_rb = 1;
      v.e_any = 0; v.e_dbg = 0;
      run(v, 101);

      v.rst = 0; v.we1 = 0; v.dbg = 6;
      run(v, 102);
      v.dbg = 5; v.ra = 7; v.rb = 9;
      run(v, 103);
    end

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
